// File: rtl/spirose_rgb_pkg.sv
// Shared types and helpers for the RGB frame writer.
package spirose_rgb_pkg;

  // Width of the frame RAM write address (64K words).
  localparam int RAM_AW = 16;

  typedef logic [RAM_AW-1:0] addr_t;

  // Writer control state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DONE  = 2'd2
  } rgb_fw_state_t;

  // Pack a {R,G,B} 8:8:8 pixel into a 5:6:5 RAM word by keeping the MSBs.
  function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/rgb_frame_writer_sync.sv
// sync_edge_detect: flags the clock on which a sync line first reaches its
// asserted level (POL). The history starts deasserted after reset, so a sync
// already asserted when reset releases is reported as an edge.
module sync_edge_detect #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic sync_edge
);

  logic prev_reg;

  // Keep the previous sample of the sync line.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= ~POL;
    end else begin
      prev_reg <= sync_in;
    end
  end

  assign sync_edge = (sync_in == POL) && (prev_reg != POL);

endmodule

// File: rtl/rgb_frame_writer.sv
// rgb_frame_writer: cuts the active window out of a parallel RGB stream,
// packs pixels to RGB565 and writes them into one of two frame banks of a
// 64K x 16 RAM. On each completed frame the banks flip and read_bank tells
// the reader which bank holds the newest full frame.
module rgb_frame_writer
  import spirose_rgb_pkg::*;
#(
  parameter int H_BP     = 16,
  parameter int H_ACTIVE = 256,
  parameter int V_BP     = 4,
  parameter int V_ACTIVE = 128,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rgb_hsync,
  input  logic        rgb_vsync,
  input  logic [23:0] rgb_d,
  output logic [15:0] ram_waddr,
  output logic [15:0] ram_wdata,
  output logic        ram_wren,
  output logic        frame_done,
  output logic        frame_error,
  output logic        read_bank,
  output logic        frame_valid
);

  localparam int H_MAX       = H_BP + H_ACTIVE;
  localparam int V_MAX       = V_BP + V_ACTIVE;
  localparam int H_W         = $clog2(H_MAX + 1);
  localparam int V_W         = $clog2(V_MAX + 1);
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;

  // Two banks must fit in the RAM, otherwise address arithmetic would wrap.
  generate
    if (2 * H_ACTIVE * V_ACTIVE > (1 << RAM_AW)) begin : g_size_check
      $error("rgb_frame_writer: 2*H_ACTIVE*V_ACTIVE exceeds RAM depth");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Sync edge detection: bit 0 = hsync, bit 1 = vsync
  // ---------------------------------------------------------------------
  logic [1:0] sync_in;
  logic [1:0] sync_edge;
  logic       hs_edge;
  logic       vs_edge;

  assign sync_in = {rgb_vsync, rgb_hsync};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      sync_edge_detect #(
        .POL(SYNC_POL)
      ) u_edge (
        .clk      (clk),
        .rst      (rst),
        .sync_in  (sync_in[gi]),
        .sync_edge(sync_edge[gi])
      );
    end
  endgenerate

  assign hs_edge = sync_edge[0];
  assign vs_edge = sync_edge[1];

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  rgb_fw_state_t  state_reg;
  rgb_fw_state_t  state_next;

  logic [H_W-1:0] h_cnt_reg;
  logic [V_W-1:0] v_cnt_reg;
  addr_t          row_reg;
  logic           line_act_reg;
  logic           wr_bank_reg;

  addr_t          ram_waddr_reg;
  logic [15:0]    ram_wdata_reg;
  logic           ram_wren_reg;
  logic           frame_done_reg;
  logic           frame_error_reg;
  logic           read_bank_reg;
  logic           frame_valid_reg;

  // ---------------------------------------------------------------------
  // Counter decode
  // ---------------------------------------------------------------------
  logic           pix_valid;
  addr_t          pixel_idx;
  addr_t          bank_base;
  addr_t          wr_addr;
  logic           last_pixel;

  logic [V_W-1:0] v_base;
  logic [V_W-1:0] v_inc;
  logic           v_in_window;
  addr_t          row_calc;

  assign pix_valid  = (h_cnt_reg >= H_W'(H_BP)) && (h_cnt_reg < H_W'(H_MAX));
  assign pixel_idx  = addr_t'(h_cnt_reg) - addr_t'(H_BP);
  assign bank_base  = wr_bank_reg ? addr_t'(FRAME_WORDS) : '0;
  assign wr_addr    = bank_base + row_reg * addr_t'(H_ACTIVE) + pixel_idx;
  assign last_pixel = (row_reg == addr_t'(V_ACTIVE - 1)) &&
                      (pixel_idx == addr_t'(H_ACTIVE - 1));

  // A vsync edge restarts the line count on this very clock, so a coincident
  // hsync is judged against line 0 rather than the stale count.
  assign v_base      = vs_edge ? '0 : v_cnt_reg;
  assign v_inc       = (v_base == V_W'(V_MAX)) ? v_base : v_base + 1'b1;
  assign v_in_window = (v_base >= V_W'(V_BP)) && (v_base < V_W'(V_MAX));
  assign row_calc    = addr_t'(v_base) - addr_t'(V_BP);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  logic count_en;
  logic wr_fire;
  logic done_fire;
  logic err_fire;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: enter FRAME on vsync, park in DONE once the last pixel lands.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (vs_edge) state_next = FRAME;
      FRAME:   if (done_fire) state_next = DONE;
      DONE:    if (vs_edge) state_next = FRAME;
      default: state_next = IDLE;
    endcase
  end

  // Per-state actions. A vsync edge inside FRAME abandons the frame, so that
  // clock neither writes nor completes; it only raises the error pulse.
  always_comb begin
    count_en  = 1'b0;
    wr_fire   = 1'b0;
    done_fire = 1'b0;
    err_fire  = 1'b0;
    case (state_reg)
      IDLE:  count_en = vs_edge;
      FRAME: begin
        count_en = 1'b1;
        if (vs_edge) begin
          err_fire = 1'b1;
        end else if (line_act_reg && pix_valid) begin
          wr_fire   = 1'b1;
          done_fire = last_pixel;
        end
      end
      DONE:    count_en = vs_edge;
      default: count_en = 1'b0;
    endcase
  end

  // Horizontal/vertical counters, write port registers and bank bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      row_reg         <= '0;
      line_act_reg    <= 1'b0;
      wr_bank_reg     <= 1'b0;
      ram_waddr_reg   <= '0;
      ram_wdata_reg   <= '0;
      ram_wren_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      read_bank_reg   <= 1'b0;
      frame_valid_reg <= 1'b0;
    end else begin
      if (hs_edge) begin
        h_cnt_reg <= '0;
      end else if (h_cnt_reg != H_W'(H_MAX)) begin
        h_cnt_reg <= h_cnt_reg + 1'b1;
      end

      if (count_en) begin
        if (hs_edge) begin
          row_reg      <= row_calc;
          line_act_reg <= v_in_window;
          v_cnt_reg    <= v_inc;
        end else if (vs_edge) begin
          v_cnt_reg    <= '0;
          line_act_reg <= 1'b0;
        end
      end

      ram_wren_reg    <= wr_fire;
      frame_done_reg  <= done_fire;
      frame_error_reg <= err_fire;

      if (wr_fire) begin
        ram_waddr_reg <= wr_addr;
        ram_wdata_reg <= rgb888_to_565(rgb_d);
      end

      if (done_fire) begin
        read_bank_reg   <= wr_bank_reg;
        frame_valid_reg <= 1'b1;
        wr_bank_reg     <= ~wr_bank_reg;
      end
    end
  end

  assign ram_waddr   = ram_waddr_reg;
  assign ram_wdata   = ram_wdata_reg;
  assign ram_wren    = ram_wren_reg;
  assign frame_done  = frame_done_reg;
  assign frame_error = frame_error_reg;
  assign read_bank   = read_bank_reg;
  assign frame_valid = frame_valid_reg;

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Directed bench for rgb_frame_writer: default (active-low) build plus an
// active-high sync build sharing clock, reset and pixel data.
module tb_rgb_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rgb_hsync = 1'b1;
  logic        rgb_vsync = 1'b1;
  logic        hs_p = 1'b0;
  logic        vs_p = 1'b0;
  logic [23:0] rgb_d = '0;

  logic [15:0] ram_waddr, ram_wdata;
  logic        ram_wren, frame_done, frame_error, read_bank, frame_valid;
  logic [15:0] p_waddr, p_wdata;
  logic        p_wren, p_done, p_error, p_read_bank, p_valid;

  rgb_frame_writer dut (
    .clk(clk), .rst(rst), .rgb_hsync(rgb_hsync), .rgb_vsync(rgb_vsync),
    .rgb_d(rgb_d), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_wren(ram_wren), .frame_done(frame_done), .frame_error(frame_error),
    .read_bank(read_bank), .frame_valid(frame_valid)
  );

  rgb_frame_writer #(.SYNC_POL(1'b1)) dut_pol (
    .clk(clk), .rst(rst), .rgb_hsync(hs_p), .rgb_vsync(vs_p),
    .rgb_d(rgb_d), .ram_waddr(p_waddr), .ram_wdata(p_wdata),
    .ram_wren(p_wren), .frame_done(p_done), .frame_error(p_error),
    .read_bank(p_read_bank), .frame_valid(p_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int          exp_base;
  int          wr_count, bad_count, done_count, err_count, first_k;
  logic [15:0] first_addr, last_addr, r2c3_addr, r2c3_data;
  int          p_wr_count, p_bad, p_first_k;
  logic [15:0] p_first_addr, p_last_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    wr_count = 0; bad_count = 0; done_count = 0; err_count = 0; first_k = -1;
    first_addr = 'x; last_addr = 'x;
    p_wr_count = 0; p_bad = 0; p_first_k = -1;
    p_first_addr = 'x; p_last_addr = 'x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the default DUT's write port against the expected pixel for this clock.
  task automatic observe(input bit ew, input logic [15:0] ea, input logic [15:0] ed,
                         input bit edn, input int k);
    if (ram_wren !== ew) bad_count++;
    if (ew && ram_wren === 1'b1 && (ram_waddr !== ea || ram_wdata !== ed)) bad_count++;
    if (ram_wren === 1'b1) begin
      if (wr_count == 0) begin
        first_addr = ram_waddr;
        first_k    = k;
      end
      last_addr = ram_waddr;
      wr_count++;
    end
    if (frame_done !== edn) bad_count++;
    if (frame_done === 1'b1) done_count++;
    if (frame_error === 1'b1) err_count++;
    if (p_wren === 1'b1) p_wr_count++;
  endtask

  // One line: hsync edge at k=0; pixel col = k-17; row < 0 means no writes.
  task automatic line(input int len, input int row, input bit with_vs);
    for (int k = 0; k < len; k++) begin
      int          col;
      bit          ew;
      logic [7:0]  r8, c8;
      logic [15:0] ea, ed;
      col       = k - 17;
      r8        = 8'(row);
      c8        = 8'(col);
      rgb_hsync = (k == 0) ? 1'b0 : 1'b1;
      rgb_vsync = (k == 0 && with_vs) ? 1'b0 : 1'b1;
      rgb_d     = {r8, c8, 8'h5A};
      tick();
      ew = (row >= 0) && (col >= 0) && (col < 256);
      ea = 16'(exp_base + row * 256 + col);
      ed = {r8[7:3], c8[7:2], 5'b01011};
      observe(ew, ea, ed, ew && row == 127 && col == 255, k);
      if (ew && row == 2 && col == 3) begin
        r2c3_addr = ram_waddr;
        r2c3_data = ram_wdata;
      end
    end
    rgb_hsync = 1'b1;
    rgb_vsync = 1'b1;
  endtask

  task automatic vsync_pulse();
    rgb_hsync = 1'b1;
    rgb_vsync = 1'b0;
    tick();
    observe(1'b0, '0, '0, 1'b0, 0);
    rgb_vsync = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      observe(1'b0, '0, '0, 1'b0, k);
    end
  endtask

  task automatic frame(input int nlines);
    vsync_pulse();
    for (int i = 0; i < 4; i++) line(4, -1, 1'b0);
    for (int r = 0; r < nlines; r++) line(273, r, 1'b0);
  endtask

  // Active-high build: hsync rises at k=0, line carries 300 active clocks.
  task automatic pline(input int len, input int row);
    for (int k = 0; k < len; k++) begin
      int          col;
      bit          ew;
      logic [7:0]  r8, c8;
      col   = k - 17;
      r8    = 8'(row);
      c8    = 8'(col);
      hs_p  = (k == 0) ? 1'b1 : 1'b0;
      rgb_d = {r8, c8, 8'h5A};
      tick();
      ew = (row >= 0) && (col >= 0) && (col < 256);
      if (p_wren !== ew) p_bad++;
      if (ew && p_wren === 1'b1 &&
          (p_waddr !== 16'(row * 256 + col) || p_wdata !== {r8[7:3], c8[7:2], 5'b01011}))
        p_bad++;
      if (p_wren === 1'b1) begin
        if (p_wr_count == 0) begin
          p_first_addr = p_waddr;
          p_first_k    = k;
        end
        p_last_addr = p_waddr;
        p_wr_count++;
      end
      if (ram_wren === 1'b1) wr_count++;
    end
    hs_p = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    exp_base = 0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_waddr", ram_waddr, 16'h0000);
    check("rst_wdata", ram_wdata, 16'h0000);
    check("rst_wren", ram_wren, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_error", frame_error, 1'b0);
    check("rst_read_bank", read_bank, 1'b0);
    check("rst_frame_valid", frame_valid, 1'b0);
    rst = 1'b0;
    idle(5);

    // Frame 1 into bank 0
    clear_stats();
    exp_base = 0;
    frame(128);
    check("f1_writes", wr_count, 32768);
    check("f1_bad", bad_count, 0);
    check("f1_first_addr", first_addr, 16'd0);
    check("f1_last_addr", last_addr, 16'd32767);
    check("f1_r2c3_addr", r2c3_addr, 16'd515);
    check("f1_r2c3_data", r2c3_data, 16'h000B);
    check("f1_done_count", done_count, 1);
    check("f1_err_count", err_count, 0);
    check("f1_read_bank", read_bank, 1'b0);
    check("f1_frame_valid", frame_valid, 1'b1);

    // Frame 2 into bank 1
    clear_stats();
    exp_base = 32768;
    frame(128);
    check("f2_writes", wr_count, 32768);
    check("f2_bad", bad_count, 0);
    check("f2_first_addr", first_addr, 16'd32768);
    check("f2_last_addr", last_addr, 16'd65535);
    check("f2_done_count", done_count, 1);
    check("f2_read_bank", read_bank, 1'b1);
    check("f2_frame_valid", frame_valid, 1'b1);

    // Early vsync after 60 active lines in bank 0
    clear_stats();
    exp_base = 0;
    frame(60);
    vsync_pulse();
    check("ab_writes", wr_count, 15360);
    check("ab_last_addr", last_addr, 16'd15359);
    check("ab_bad", bad_count, 0);
    check("ab_err_count", err_count, 1);
    check("ab_done_count", done_count, 0);
    check("ab_read_bank", read_bank, 1'b1);
    clear_stats();
    for (int i = 0; i < 4; i++) line(4, -1, 1'b0);
    line(273, 0, 1'b0);
    check("ab_restart_writes", wr_count, 256);
    check("ab_restart_first", first_addr, 16'd0);
    check("ab_restart_bad", bad_count, 0);

    // Coincident vsync+hsync: that hsync is line 0, 5th hsync is row 0
    clear_stats();
    line(4, -1, 1'b1);
    line(4, -1, 1'b0);
    line(4, -1, 1'b0);
    line(273, -1, 1'b0);
    line(273, 0, 1'b0);
    check("co_err_count", err_count, 1);
    check("co_bad", bad_count, 0);
    check("co_writes", wr_count, 256);
    check("co_first_addr", first_addr, 16'd0);
    check("co_first_k", first_k, 17);

    // Reset mid-line (row 1, pixel 82 just written)
    clear_stats();
    line(100, 1, 1'b0);
    check("mr_pre_writes", wr_count, 83);
    check("mr_pre_bad", bad_count, 0);
    rst = 1'b1;
    tick();
    check("mr_waddr", ram_waddr, 16'h0000);
    check("mr_wdata", ram_wdata, 16'h0000);
    check("mr_wren", ram_wren, 1'b0);
    check("mr_done", frame_done, 1'b0);
    check("mr_error", frame_error, 1'b0);
    check("mr_read_bank", read_bank, 1'b0);
    check("mr_frame_valid", frame_valid, 1'b0);
    rst = 1'b0;
    clear_stats();
    idle(200);
    line(273, -1, 1'b0);
    line(273, -1, 1'b0);
    check("mr_idle_writes", wr_count, 0);
    check("mr_idle_bad", bad_count, 0);
    clear_stats();
    exp_base = 0;
    frame(1);
    check("mr_fresh_writes", wr_count, 256);
    check("mr_fresh_first", first_addr, 16'd0);
    check("mr_fresh_bad", bad_count, 0);
    check("mr_fresh_err", err_count, 0);

    // Active-high sync build, 300 active clocks per line
    clear_stats();
    vs_p = 1'b1;
    tick();
    vs_p = 1'b0;
    for (int i = 0; i < 4; i++) pline(4, -1);
    pline(316, 0);
    pline(316, 1);
    check("pol_writes", p_wr_count, 512);
    check("pol_first_k", p_first_k, 17);
    check("pol_first_addr", p_first_addr, 16'd0);
    check("pol_last_addr", p_last_addr, 16'd511);
    check("pol_bad", p_bad, 0);
    check("pol_main_quiet", wr_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
